apb_master_bridge: RTL and testbench

Single-outstanding APB requester driving the `slave` memory block. Accepts read/write commands on a valid/ready command port. Runs the APB SETUP/ACCESS phases, waits on `pready`, and returns read data and error status on a valid/ready response port. It has a wait-state timeout so a hung slave cannot stall the system.

---
 rtl/apb_pkg.sv | 15 +
 rtl/apb_master_bridge.sv | 115 +++++++++++
 tb/tb_apb_master_bridge.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: bridge FSM state encoding and default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // Default bus widths, shared between the bridge and the slave memory block.
    localparam int unsigned APB_WIDTH      = 32;
    localparam int unsigned APB_ADDR_WIDTH = 8;

endpackage

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester.
// A command is taken on a valid/ready port and run through the APB SETUP and
// ACCESS phases. The result comes back on a valid/ready response port. A
// wait-state timeout aborts transfers to a slave that never raises pready.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned WIDTH      = APB_WIDTH,
    parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    // command port
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [WIDTH-1:0]      cmd_wdata,
    // response port
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB requester
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [WIDTH-1:0]      pwdata,
    input  logic [WIDTH-1:0]      prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;

    // Bridge FSM: every output is registered and updated alongside the state.
    // cmd_ready is held as a flag that tracks state == IDLE. This lets it
    // stay low through reset and rise on the first clock edge after release.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        pwrite    <= cmd_write;
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        psel      <= 1'b1;
                        penable   <= 1'b0;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed testbench for apb_master_bridge, run against a small behavioural
// APB memory slave that has a configurable wait count, error flag and hang
// mode.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        presetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int n_checks = 0;
    int n_pass   = 0;

    // slave configuration (driven by the stimulus process only)
    int   wait_cfg = 0;
    logic hang     = 1'b0;
    logic err_cfg  = 1'b0;

    logic [31:0] mem [0:255];
    int          acc_cnt = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(
        .WIDTH      (32),
        .ADDR_WIDTH (8),
        .TIMEOUT    (4)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // behavioural slave: pready after wait_cfg ACCESS cycles, unless hung
    assign pready  = psel && penable && !hang && (acc_cnt >= wait_cfg);
    assign prdata  = mem[paddr];
    assign pslverr = pready && err_cfg;

    // slave wait counter and memory write port
    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Issue one command and collect its response together with APB phase statistics.
    task automatic do_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output logic [31:0] rd, output logic err, output logic to,
                           output int lat, output int psel_n, output int pen_n,
                           output logic addr_ok, output logic cr_after);
        int guard;
        rd = '0; err = 1'b0; to = 1'b0; lat = 0; psel_n = 0; pen_n = 0;
        addr_ok = 1'b1; cr_after = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        guard = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        if (!cmd_ready) begin
            check("accept_bound", 64'd0, 64'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge pclk);
        #1 cmd_valid = 1'b0;
        while (lat < 40) begin
            @(negedge pclk);
            lat++;
            if (psel) begin
                psel_n++;
                if (paddr !== a || pwrite !== wr) addr_ok = 1'b0;
            end
            if (penable) pen_n++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            check("rsp_bound", 64'd0, 64'd1);
            return;
        end
        rd = rsp_rdata; err = rsp_err; to = rsp_timeout;
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        @(negedge pclk);
        cr_after = cmd_ready && !rsp_valid;
    endtask

    logic [31:0] rd, snap_rd;
    logic        err, to, aok, cra, snap_err, stable, no_setup, cr_low;
    int          lat, pn, en, guard;

    initial begin
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; rsp_ready = 1'b0;

        // reset state
        #12;
        check("rst_psel",      64'(psel), 64'd0);
        check("rst_penable",   64'(penable), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_paddr",     64'({paddr, pwdata, pwrite}), 64'd0);
        check("rst_rsp",       64'({rsp_rdata, rsp_err, rsp_timeout}), 64'd0);
        @(negedge pclk); presetn = 1'b1;
        @(negedge pclk);
        check("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // write then read back, 1 wait state
        wait_cfg = 1;
        do_xfer(1'b1, 8'h10, 32'hDEADBEEF, rd, err, to, lat, pn, en, aok, cra);
        check("wr_err",    64'(err), 64'd0);
        check("wr_rdata",  64'(rd), 64'd0);
        check("wr_psel_n", 64'(pn), 64'd3);
        check("wr_addr",   64'(aok), 64'd1);
        do_xfer(1'b0, 8'h10, 32'h0, rd, err, to, lat, pn, en, aok, cra);
        check("rd_rdata",  64'(rd), 64'hDEADBEEF);
        check("rd_err",    64'({err, to}), 64'd0);
        check("rd_psel_n", 64'(pn), 64'd3);
        check("rd_addr",   64'(aok), 64'd1);
        check("rd_lat",    64'(lat), 64'd4);

        // zero wait states
        wait_cfg = 0;
        do_xfer(1'b1, 8'h33, 32'h0000005A, rd, err, to, lat, pn, en, aok, cra);
        check("zw_wr_lat", 64'(lat), 64'd3);
        do_xfer(1'b0, 8'h33, 32'h0, rd, err, to, lat, pn, en, aok, cra);
        check("zw_rd_lat",   64'(lat), 64'd3);
        check("zw_rd_rdata", 64'(rd), 64'h5A);
        check("zw_psel_n",   64'(pn), 64'd2);
        check("zw_cmd_ready_after", 64'(cra), 64'd1);

        // slave error on the pready cycle
        wait_cfg = 1; err_cfg = 1'b1;
        do_xfer(1'b0, 8'h20, 32'h0, rd, err, to, lat, pn, en, aok, cra);
        check("slverr_err",     64'(err), 64'd1);
        check("slverr_timeout", 64'(to), 64'd0);
        err_cfg = 1'b0;

        // timeout with pready held low
        hang = 1'b1;
        do_xfer(1'b0, 8'h10, 32'h0, rd, err, to, lat, pn, en, aok, cra);
        check("to_penable_n", 64'(en), 64'd4);
        check("to_err",       64'(err), 64'd1);
        check("to_timeout",   64'(to), 64'd1);
        check("to_rdata",     64'(rd), 64'd0);
        hang = 1'b0;

        // timeout boundary: pready on the last allowed ACCESS cycle wins
        wait_cfg = 3;
        do_xfer(1'b0, 8'h10, 32'h0, rd, err, to, lat, pn, en, aok, cra);
        check("edge_timeout", 64'({err, to}), 64'd0);
        check("edge_rdata",   64'(rd), 64'hDEADBEEF);
        check("edge_pen_n",   64'(en), 64'd4);

        // backpressure on the response port
        wait_cfg = 0;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = '0;
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(posedge pclk);
            #1 if (psel) cmd_addr = 8'h33;
            @(negedge pclk);
            guard++;
        end
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        snap_rd = rsp_rdata; snap_err = rsp_err;
        stable = 1'b1; no_setup = 1'b1; cr_low = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            if (cmd_ready) cr_low = 1'b0;
            if (psel) no_setup = 1'b0;
            if (!rsp_valid || rsp_rdata !== snap_rd || rsp_err !== snap_err) stable = 1'b0;
        end
        check("bp_cmd_ready_low", 64'(cr_low), 64'd1);
        check("bp_no_setup",      64'(no_setup), 64'd1);
        check("bp_rsp_stable",    64'(stable), 64'd1);
        check("bp_rdata",         64'(snap_rd), 64'hDEADBEEF);
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;
        guard = 0;
        while (!rsp_valid && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        cmd_valid = 1'b0;
        check("bp_second_rdata", 64'(rsp_rdata), 64'h5A);
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1 rsp_ready = 1'b0;

        // reset during a wait state
        hang = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h10;
        guard = 0;
        while (!penable && guard < 20) begin
            @(negedge pclk);
            guard++;
        end
        cmd_valid = 1'b0;
        check("mid_in_access", 64'(penable), 64'd1);
        @(posedge pclk);
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_apb",       64'({psel, penable}), 64'd0);
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge pclk);
        presetn = 1'b1; hang = 1'b0;
        @(negedge pclk);
        check("mid_cmd_ready", 64'(cmd_ready), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (rsp_valid || psel) stable = 1'b0;
        end
        check("mid_no_stale_rsp", 64'(stable), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // absolute run-time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
